// File: rtl/ecg_layer_sequencer.sv
// ---------------------------------------------------------------------------
// ecg_layer_sequencer
//
// Descriptor-driven layer sequencer for the ECG CNN accelerator. Walks a small
// table of CONV / POOL / FC descriptors and, for each layer, issues
// taps*outs feature/weight buffer reads. It streams the returned xin/win
// pairs to the PE under pe_ready backpressure and drives the per-layer
// datapath selects for the ReLU / MaxPooling / ControlBuffer / Softmax stages.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   cfg_we/idx/data       descriptor table write port (IDLE only)
//   start                 launch the sequence at slot 0 (IDLE only)
//   busy, done, cfg_err   sequence status; cfg_err pulses with done when
//                         slot 0 holds END
//   rd_en, x_addr, w_addr buffer read strobe and addresses
//   x_rdata, w_rdata      buffer data, valid the cycle after rd_en
//   xin, win, pe_valid    pair to the PE (data masked to 0 when not valid)
//   pe_ready              PE accepts a pair in the following cycle
//   out_strobe            marks the last tap of each output
//   layer_idx             current descriptor slot
//   S1..S6, accumulate_en, softmax_en, store_en   datapath controls
//
// Descriptor: [31:30] op, [29:25] taps, [24:15] outs,
//             [14:8] {S1,S2,S3,S5[1:0],S6[1:0]}, [7] store_en, [6:0] reserved
// ---------------------------------------------------------------------------
module ecg_layer_sequencer #(
    parameter int N          = 16,
    parameter int AW         = 10,
    parameter int MAX_LAYERS = 8,
    localparam int LW        = (MAX_LAYERS > 1) ? $clog2(MAX_LAYERS) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cfg_we,
    input  logic [LW-1:0] cfg_idx,
    input  logic [31:0]   cfg_data,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          cfg_err,
    output logic          rd_en,
    output logic [AW-1:0] x_addr,
    output logic [AW-1:0] w_addr,
    input  logic [N-1:0]  x_rdata,
    input  logic [N-1:0]  w_rdata,
    output logic [N-1:0]  xin,
    output logic [N-1:0]  win,
    output logic          pe_valid,
    input  logic          pe_ready,
    output logic          out_strobe,
    output logic [LW-1:0] layer_idx,
    output logic          S1,
    output logic          S2,
    output logic          S3,
    output logic [1:0]    S5,
    output logic [1:0]    S6,
    output logic          accumulate_en,
    output logic          softmax_en,
    output logic          store_en
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        OP_END  = 2'd0,
        OP_CONV = 2'd1,
        OP_POOL = 2'd2,
        OP_FC   = 2'd3
    } op_e;

    // Reserved descriptor bits are never stored.
    logic unused_reserved;
    assign unused_reserved = ^cfg_data[6:0];

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e          state_q;
    logic [31:7]     desc_q [MAX_LAYERS];
    logic [LW-1:0]   layer_q;
    op_e             op_q;
    logic [4:0]      taps_q;
    logic [9:0]      outs_q;
    logic [6:0]      flags_q;
    logic            store_q;
    logic [4:0]      tap_cnt_q;
    logic [9:0]      out_cnt_q;
    logic [AW-1:0]   w_cnt_q;
    logic            err_q;
    logic            pe_valid_q;
    logic            strobe_q;

    // ------------------------------------------------------------------
    // Descriptor decode for the slot being loaded. The table entry is read
    // live during LOAD so a write in the start cycle is already visible.
    // ------------------------------------------------------------------
    logic [31:7] ld_desc;
    op_e         ld_op;
    logic [4:0]  ld_taps;
    logic [9:0]  ld_outs;

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        ld_desc = desc_q[layer_q];
        ld_op   = op_e'(ld_desc[31:30]);
        ld_taps = ld_desc[29:25];
        ld_outs = ld_desc[24:15];
        if (ld_op == OP_POOL) begin
            ld_taps = 5'd2;              // pooling window is always a pair
        end else if (ld_taps == 5'd0) begin
            ld_taps = 5'd1;
        end
        if (ld_outs == 10'd0) begin
            ld_outs = 10'd1;
        end
    end

    logic issue;
    logic last_tap;
    logic last_out;

    assign issue    = (state_q == ST_RUN) && pe_ready;
    assign last_tap = (tap_cnt_q == taps_q - 5'd1);
    assign last_out = (out_cnt_q == outs_q - 10'd1);

    // ------------------------------------------------------------------
    // Sequencer FSM, descriptor table and output pipeline
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            layer_q    <= '0;
            op_q       <= OP_END;
            taps_q     <= 5'd1;
            outs_q     <= 10'd1;
            flags_q    <= '0;
            store_q    <= 1'b0;
            tap_cnt_q  <= '0;
            out_cnt_q  <= '0;
            w_cnt_q    <= '0;
            err_q      <= 1'b0;
            pe_valid_q <= 1'b0;
            strobe_q   <= 1'b0;
            // NOTE: the table is reset explicitly (all END) because a reset
            // mid-sequence must not leave stale layers behind.
            for (int i = 0; i < MAX_LAYERS; i++) begin
                desc_q[i] <= '0;
            end
        end else begin
            pe_valid_q <= issue;
            strobe_q   <= issue && last_tap;

            case (state_q)
                ST_IDLE: begin
                    if (cfg_we) begin
                        desc_q[cfg_idx] <= cfg_data[31:7];
                    end
                    if (start) begin
                        state_q <= ST_LOAD;
                        layer_q <= '0;
                        w_cnt_q <= '0;
                        err_q   <= 1'b0;
                    end
                end

                ST_LOAD: begin
                    op_q      <= ld_op;
                    taps_q    <= ld_taps;
                    outs_q    <= ld_outs;
                    flags_q   <= ld_desc[14:8];
                    store_q   <= ld_desc[7];
                    tap_cnt_q <= '0;
                    out_cnt_q <= '0;
                    if (ld_op == OP_END) begin
                        state_q <= ST_DONE;
                        if (layer_q == '0) begin
                            err_q <= 1'b1;
                        end
                    end else begin
                        state_q <= ST_RUN;
                    end
                end

                ST_RUN: begin
                    // A stalled cycle leaves every counter untouched.
                    if (pe_ready) begin
                        w_cnt_q <= w_cnt_q + AW'(1);
                        if (last_tap) begin
                            tap_cnt_q <= '0;
                            if (last_out) begin
                                state_q <= ST_DRAIN;
                            end else begin
                                out_cnt_q <= out_cnt_q + 10'd1;
                            end
                        end else begin
                            tap_cnt_q <= tap_cnt_q + 5'd1;
                        end
                    end
                end

                ST_DRAIN: begin
                    if (layer_q == LW'(MAX_LAYERS - 1)) begin
                        state_q <= ST_DONE;
                    end else begin
                        layer_q <= layer_q + LW'(1);
                        state_q <= ST_LOAD;
                    end
                end

                ST_DONE: begin
                    state_q <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Addresses
    // ------------------------------------------------------------------
    always_comb begin
        x_addr = AW'(tap_cnt_q);
        case (op_q)
            OP_CONV: x_addr = AW'(out_cnt_q) + AW'(tap_cnt_q);
            OP_POOL: x_addr = AW'({out_cnt_q, 1'b0}) + AW'(tap_cnt_q);
            default: x_addr = AW'(tap_cnt_q);
        endcase
    end

    assign w_addr = w_cnt_q;
    assign rd_en  = issue;

    // ------------------------------------------------------------------
    // Datapath controls: live descriptor in LOAD, latched copy in RUN/DRAIN
    // ------------------------------------------------------------------
    logic [6:0] ctl_flags;
    logic       ctl_store;
    logic       ctl_fc;

    always_comb begin
        ctl_flags = '0;
        ctl_store = 1'b0;
        ctl_fc    = 1'b0;
        case (state_q)
            ST_LOAD: begin
                ctl_flags = ld_desc[14:8];
                ctl_store = ld_desc[7];
                ctl_fc    = (ld_op == OP_FC);
            end
            ST_RUN, ST_DRAIN: begin
                ctl_flags = flags_q;
                ctl_store = store_q;
                ctl_fc    = (op_q == OP_FC);
            end
            default: ;
        endcase
    end

    assign S1            = ctl_flags[6];
    assign S2            = ctl_flags[5];
    assign S3            = ctl_flags[4];
    assign S5            = ctl_flags[3:2];
    assign S6            = ctl_flags[1:0];
    assign store_en      = ctl_store;
    assign accumulate_en = ctl_fc;
    assign softmax_en    = ctl_fc;

    // ------------------------------------------------------------------
    // Status and PE stream
    // ------------------------------------------------------------------
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);
    assign cfg_err    = (state_q == ST_DONE) && err_q;
    assign layer_idx  = layer_q;
    assign pe_valid   = pe_valid_q;
    assign out_strobe = strobe_q;
    assign xin        = pe_valid_q ? x_rdata : '0;
    assign win        = pe_valid_q ? w_rdata : '0;

endmodule

// File: tb/tb_ecg_layer_sequencer.sv
// ---------------------------------------------------------------------------
// Directed testbench for ecg_layer_sequencer. Each scenario runs one
// sequence through run_seq, which logs every cycle's outputs (cycle 0 is the
// start cycle), then compares the log with hand-derived expectations. A small
// buffer model returns {tag, address} one cycle after each rd_en.
// ---------------------------------------------------------------------------
module tb_ecg_layer_sequencer;

    localparam int N    = 16;
    localparam int AW   = 10;
    localparam int MAXC = 48;

    localparam logic [1:0] OP_END  = 2'd0;
    localparam logic [1:0] OP_CONV = 2'd1;
    localparam logic [1:0] OP_POOL = 2'd2;
    localparam logic [1:0] OP_FC   = 2'd3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_we = 1'b0;
    logic [2:0]    cfg_idx = '0;
    logic [31:0]   cfg_data = '0;
    logic          start = 1'b0;
    logic          busy, done, cfg_err, rd_en;
    logic [AW-1:0] x_addr, w_addr;
    logic [N-1:0]  x_rdata = 16'hDEAD;
    logic [N-1:0]  w_rdata = 16'hBEEF;
    logic [N-1:0]  xin, win;
    logic          pe_valid;
    logic          pe_ready = 1'b1;
    logic          out_strobe;
    logic [2:0]    layer_idx;
    logic          S1, S2, S3;
    logic [1:0]    S5, S6;
    logic          accumulate_en, softmax_en, store_en;

    ecg_layer_sequencer #(.N(N), .AW(AW), .MAX_LAYERS(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_we        (cfg_we),
        .cfg_idx       (cfg_idx),
        .cfg_data      (cfg_data),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .cfg_err       (cfg_err),
        .rd_en         (rd_en),
        .x_addr        (x_addr),
        .w_addr        (w_addr),
        .x_rdata       (x_rdata),
        .w_rdata       (w_rdata),
        .xin           (xin),
        .win           (win),
        .pe_valid      (pe_valid),
        .pe_ready      (pe_ready),
        .out_strobe    (out_strobe),
        .layer_idx     (layer_idx),
        .S1            (S1),
        .S2            (S2),
        .S3            (S3),
        .S5            (S5),
        .S6            (S6),
        .accumulate_en (accumulate_en),
        .softmax_en    (softmax_en),
        .store_en      (store_en)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Per-cycle log of one sequence
    logic          log_rd   [MAXC];
    logic [AW-1:0] log_xa   [MAXC];
    logic [AW-1:0] log_wa   [MAXC];
    logic          log_pv   [MAXC];
    logic          log_os   [MAXC];
    logic [N-1:0]  log_xin  [MAXC];
    logic [N-1:0]  log_win  [MAXC];
    logic          log_busy [MAXC];
    logic          log_err  [MAXC];
    logic          log_acc  [MAXC];
    logic          log_smx  [MAXC];
    logic          log_s3   [MAXC];
    logic [1:0]    log_s5   [MAXC];
    logic          log_st   [MAXC];
    logic [69:0]   log_all  [MAXC];
    int            done_cyc;

    function automatic logic [31:0] mk(input logic [1:0] op, input logic [4:0] taps,
                                       input logic [9:0] outs, input logic [6:0] flags,
                                       input logic st);
        return {op, taps, outs, flags, st, 7'b0};
    endfunction

    function automatic logic [69:0] all_outs();
        return {busy, done, cfg_err, rd_en, x_addr, w_addr, xin, win, pe_valid,
                out_strobe, layer_idx, S1, S2, S3, S5, S6, accumulate_en,
                softmax_en, store_en};
    endfunction

    task automatic write_desc(input logic [2:0] idx, input logic [31:0] d);
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_idx  = idx;
        cfg_data = d;
        @(negedge clk);
        cfg_we   = 1'b0;
    endtask

    // ready_mode 0: pe_ready always 1; 1: pe_ready high on odd cycles.
    // we0: write d0 to slot 0 in the start cycle. busy_wr: try a slot-1 write
    // at cycle 3. restart_at / rst_at: cycle for a second start / reset pulse.
    task automatic run_seq(input int ready_mode, input logic we0, input logic [31:0] d0,
                           input logic busy_wr, input int restart_at, input int rst_at);
        logic          pend;
        logic [AW-1:0] pxa, pwa;
        pend     = 1'b0;
        pxa      = '0;
        pwa      = '0;
        done_cyc = -1;
        for (int c = 0; c < MAXC; c++) begin
            @(negedge clk);
            start    = (c == 0) || (c == restart_at);
            rst_n    = (c != rst_at);
            cfg_we   = (we0 && c == 0) || (busy_wr && c == 3);
            cfg_idx  = (c == 3) ? 3'd1 : 3'd0;
            cfg_data = (c == 3) ? mk(OP_CONV, 5'd1, 10'd1, 7'd0, 1'b0) : d0;
            pe_ready = (ready_mode == 0) ? 1'b1 : 1'(c % 2);
            x_rdata  = pend ? {6'h28, pxa} : 16'hDEAD;
            w_rdata  = pend ? {6'h31, pwa} : 16'hBEEF;
            #1;
            log_rd[c]   = rd_en;
            log_xa[c]   = x_addr;
            log_wa[c]   = w_addr;
            log_pv[c]   = pe_valid;
            log_os[c]   = out_strobe;
            log_xin[c]  = xin;
            log_win[c]  = win;
            log_busy[c] = busy;
            log_err[c]  = cfg_err;
            log_acc[c]  = accumulate_en;
            log_smx[c]  = softmax_en;
            log_s3[c]   = S3;
            log_s5[c]   = S5;
            log_st[c]   = store_en;
            log_all[c]  = all_outs();
            if (done && done_cyc < 0) done_cyc = c;
            pend = rd_en;
            pxa  = x_addr;
            pwa  = w_addr;
        end
        start    = 1'b0;
        cfg_we   = 1'b0;
        rst_n    = 1'b1;
        pe_ready = 1'b1;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (all_outs() !== 70'd0) begin
            errors++;
            $display("FAIL reset_outputs got=%h exp=0", all_outs());
        end
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (all_outs() !== 70'd0) begin
            errors++;
            $display("FAIL idle_outputs got=%h exp=0", all_outs());
        end
    endtask

    task automatic test_conv();
        logic [AW-1:0] ex;
        logic          eo;
        write_desc(3'd0, mk(OP_CONV, 5'd3, 10'd4, 7'd0, 1'b0));
        write_desc(3'd1, mk(OP_END, 5'd0, 10'd0, 7'd0, 1'b0));
        run_seq(0, 1'b0, '0, 1'b0, -1, -1);
        checks++;
        if (done_cyc !== 16) begin
            errors++;
            $display("FAIL conv_done_cycle got=%0d exp=16", done_cyc);
        end
        for (int c = 0; c < MAXC; c++) begin
            checks++;
            if (log_pv[c] !== ((c >= 3) && (c <= 14))) begin
                errors++;
                $display("FAIL conv_pe_valid c=%0d got=%b", c, log_pv[c]);
            end
            eo = (c == 5) || (c == 8) || (c == 11) || (c == 14);
            checks++;
            if (log_os[c] !== eo) begin
                errors++;
                $display("FAIL conv_out_strobe c=%0d got=%b exp=%b", c, log_os[c], eo);
            end
        end
        for (int i = 0; i < 12; i++) begin
            ex = AW'(i / 3 + i % 3);
            checks++;
            if (log_rd[i+2] !== 1'b1 || log_xa[i+2] !== ex || log_wa[i+2] !== AW'(i)) begin
                errors++;
                $display("FAIL conv_issue i=%0d got rd=%b x=%0d w=%0d exp rd=1 x=%0d w=%0d",
                         i, log_rd[i+2], log_xa[i+2], log_wa[i+2], ex, i);
            end
            checks++;
            if (log_xin[i+3] !== {6'h28, ex} || log_win[i+3] !== {6'h31, AW'(i)}) begin
                errors++;
                $display("FAIL conv_pe_data i=%0d got xin=%h win=%h exp xin=%h win=%h",
                         i, log_xin[i+3], log_win[i+3], {6'h28, ex}, {6'h31, AW'(i)});
            end
        end
        checks++;
        if (log_xin[2] !== 16'h0 || log_win[2] !== 16'h0) begin
            errors++;
            $display("FAIL conv_data_mask got xin=%h win=%h exp=0", log_xin[2], log_win[2]);
        end
        checks++;
        if (log_busy[0] !== 1'b0 || log_busy[1] !== 1'b1 || log_busy[17] !== 1'b0
            || log_err[16] !== 1'b0) begin
            errors++;
            $display("FAIL conv_status got busy0=%b busy1=%b busy17=%b err16=%b exp 0 1 0 0",
                     log_busy[0], log_busy[1], log_busy[17], log_err[16]);
        end
    endtask

    task automatic test_conv_fc();
        int            wi;
        logic          er, ea;
        write_desc(3'd0, mk(OP_CONV, 5'd2, 10'd2, 7'd0, 1'b0));
        write_desc(3'd1, mk(OP_FC, 5'd3, 10'd1, 7'd0, 1'b0));
        write_desc(3'd2, mk(OP_END, 5'd0, 10'd0, 7'd0, 1'b0));
        run_seq(0, 1'b0, '0, 1'b0, -1, -1);
        checks++;
        if (done_cyc !== 13) begin
            errors++;
            $display("FAIL fc_done_cycle got=%0d exp=13", done_cyc);
        end
        wi = 0;
        for (int c = 0; c < MAXC; c++) begin
            er = ((c >= 2) && (c <= 5)) || ((c >= 8) && (c <= 10));
            ea = (c >= 7) && (c <= 11);
            checks++;
            if (log_rd[c] !== er) begin
                errors++;
                $display("FAIL fc_rd_en c=%0d got=%b exp=%b", c, log_rd[c], er);
            end
            checks++;
            if (log_acc[c] !== ea || log_smx[c] !== ea) begin
                errors++;
                $display("FAIL fc_acc_softmax c=%0d got acc=%b smx=%b exp=%b",
                         c, log_acc[c], log_smx[c], ea);
            end
            if (er) begin
                checks++;
                if (log_wa[c] !== AW'(wi)) begin
                    errors++;
                    $display("FAIL fc_w_addr c=%0d got=%0d exp=%0d", c, log_wa[c], wi);
                end
                wi++;
            end
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (log_xa[8+i] !== AW'(i)) begin
                errors++;
                $display("FAIL fc_x_addr i=%0d got=%0d exp=%0d", i, log_xa[8+i], i);
            end
        end
    endtask

    task automatic test_pool();
        logic es;
        // flags {S1,S2,S3,S5,S6} = {0,0,1,2'b10,2'b00}, store_en=1
        write_desc(3'd0, mk(OP_POOL, 5'd7, 10'd3, 7'b0011000, 1'b1));
        write_desc(3'd1, mk(OP_END, 5'd0, 10'd0, 7'd0, 1'b0));
        run_seq(0, 1'b0, '0, 1'b0, -1, -1);
        checks++;
        if (done_cyc !== 10) begin
            errors++;
            $display("FAIL pool_done_cycle got=%0d exp=10", done_cyc);
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (log_rd[2+i] !== 1'b1 || log_xa[2+i] !== AW'(i)) begin
                errors++;
                $display("FAIL pool_x_addr i=%0d got rd=%b x=%0d exp rd=1 x=%0d",
                         i, log_rd[2+i], log_xa[2+i], i);
            end
        end
        for (int c = 0; c < 12; c++) begin
            es = (c >= 1) && (c <= 8);
            checks++;
            if (log_s3[c] !== es || log_st[c] !== es) begin
                errors++;
                $display("FAIL pool_s3_store c=%0d got s3=%b st=%b exp=%b",
                         c, log_s3[c], log_st[c], es);
            end
        end
        checks++;
        if (log_s5[4] !== 2'b10 || log_acc[4] !== 1'b0) begin
            errors++;
            $display("FAIL pool_s5 got s5=%b acc=%b exp s5=10 acc=0", log_s5[4], log_acc[4]);
        end
    endtask

    task automatic test_backpressure();
        logic          er, ep;
        int            k;
        logic [AW-1:0] exa [4];
        exa[0] = 10'd0; exa[1] = 10'd1; exa[2] = 10'd1; exa[3] = 10'd2;
        write_desc(3'd0, mk(OP_CONV, 5'd2, 10'd2, 7'd0, 1'b0));
        write_desc(3'd1, mk(OP_END, 5'd0, 10'd0, 7'd0, 1'b0));
        run_seq(1, 1'b0, '0, 1'b0, -1, -1);
        checks++;
        if (done_cyc !== 12) begin
            errors++;
            $display("FAIL bp_done_cycle got=%0d exp=12", done_cyc);
        end
        k = 0;
        for (int c = 0; c < MAXC; c++) begin
            er = (c == 3) || (c == 5) || (c == 7) || (c == 9);
            ep = (c == 4) || (c == 6) || (c == 8) || (c == 10);
            checks++;
            if (log_rd[c] !== er || log_pv[c] !== ep) begin
                errors++;
                $display("FAIL bp_handshake c=%0d got rd=%b pv=%b exp rd=%b pv=%b",
                         c, log_rd[c], log_pv[c], er, ep);
            end
            if (er) begin
                checks++;
                if (log_xa[c] !== exa[k] || log_wa[c] !== AW'(k)) begin
                    errors++;
                    $display("FAIL bp_addr k=%0d got x=%0d w=%0d exp x=%0d w=%0d",
                             k, log_xa[c], log_wa[c], exa[k], k);
                end
                k++;
            end
        end
    endtask

    task automatic test_write_start();
        // slot 0 currently CONV; new FC descriptor written in the start cycle,
        // and a slot-1 write while busy must be dropped (slot 1 stays END).
        run_seq(0, 1'b1, mk(OP_FC, 5'd1, 10'd1, 7'd0, 1'b0), 1'b1, -1, -1);
        checks++;
        if (log_acc[1] !== 1'b1) begin
            errors++;
            $display("FAIL ws_new_desc got acc=%b exp=1", log_acc[1]);
        end
        checks++;
        if (done_cyc !== 5) begin
            errors++;
            $display("FAIL ws_busy_write_dropped got done=%0d exp=5", done_cyc);
        end
        checks++;
        if (log_rd[2] !== 1'b1 || log_rd[3] !== 1'b0) begin
            errors++;
            $display("FAIL ws_single_issue got rd2=%b rd3=%b exp 1 0", log_rd[2], log_rd[3]);
        end
    endtask

    task automatic test_cfg_err();
        int nrd;
        write_desc(3'd0, mk(OP_END, 5'd0, 10'd0, 7'd0, 1'b0));
        run_seq(0, 1'b0, '0, 1'b0, 2, -1);
        checks++;
        if (done_cyc !== 2 || log_err[2] !== 1'b1) begin
            errors++;
            $display("FAIL end_done_err got done=%0d err=%b exp done=2 err=1",
                     done_cyc, log_err[2]);
        end
        nrd = 0;
        for (int c = 0; c < MAXC; c++) nrd += int'(log_rd[c]);
        checks++;
        if (nrd !== 0) begin
            errors++;
            $display("FAIL end_no_reads got=%0d exp=0", nrd);
        end
        checks++;
        if (log_busy[3] !== 1'b0) begin
            errors++;
            $display("FAIL end_start_at_done_ignored got busy=%b exp=0", log_busy[3]);
        end
    endtask

    task automatic test_reset_mid_run();
        write_desc(3'd0, mk(OP_CONV, 5'd3, 10'd4, 7'b1111111, 1'b1));
        write_desc(3'd1, mk(OP_END, 5'd0, 10'd0, 7'd0, 1'b0));
        run_seq(0, 1'b0, '0, 1'b0, -1, 5);
        checks++;
        if (log_busy[4] !== 1'b1 || log_rd[4] !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre_running got busy=%b rd=%b exp 1 1", log_busy[4], log_rd[4]);
        end
        checks++;
        if (log_all[6] !== 70'd0) begin
            errors++;
            $display("FAIL rst_mid_outputs got=%h exp=0", log_all[6]);
        end
        run_seq(0, 1'b0, '0, 1'b0, -1, -1);
        checks++;
        if (done_cyc !== 2 || log_err[2] !== 1'b1) begin
            errors++;
            $display("FAIL rst_table_cleared got done=%0d err=%b exp done=2 err=1",
                     done_cyc, log_err[2]);
        end
    endtask

    initial begin
        test_reset();
        test_conv();
        test_conv_fc();
        test_pool();
        test_backpressure();
        test_write_start();
        test_cfg_err();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ecg_layer_sequencer.md
# ecg_layer_sequencer

Programmable layer sequencer for the ECG CNN accelerator. It walks a small descriptor table (CONV / POOL / FC layers) and generates feature and weight buffer read addresses. It streams the returned xin/win pairs into the PE under a ready/valid handshake and drives the per-layer datapath selects (S1, S2, S3, S5, S6, accumulate_en, store_en, softmax_en) for the ReLU, MaxPooling, ControlBuffer and Softmax stages. It replaces hard-coded per-state cycle counts with descriptor-driven tap/output counts and supports backpressure.

## Interface
Parameters:
- N, 16, data width of xin/win
- AW, 10, buffer address width
- MAX_LAYERS, 8, descriptor table depth (index width LW = 3)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- cfg_we  in  1  descriptor write strobe; ignored while busy
- cfg_idx  in  3  descriptor slot
- cfg_data  in  32  descriptor: [31:30] op (0=END, 1=CONV, 2=POOL, 3=FC); [29:25] taps; [24:15] outs; [14:8] flags {S1, S2, S3, S5[1:0], S6[1:0]}; [7] store_en; [6:0] reserved
- start  in  1  begin sequence at slot 0; ignored while busy
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse at sequence end
- cfg_err  out  1  pulses with done if slot 0 is END
- rd_en  out  1  buffer read strobe; data returns next cycle
- x_addr, w_addr  out  AW  feature / weight read addresses
- x_rdata, w_rdata  in  N  buffer read data, valid the cycle after rd_en
- xin, win  out  N  to PE; combinational pass-through of x_rdata / w_rdata
- pe_valid  out  1  xin/win valid
- pe_ready  in  1  PE can accept a pair in the following cycle
- out_strobe  out  1  with pe_valid on the last tap of each output
- layer_idx  out  3  current slot
- S1, S2, S3  out  1  datapath selects
- S5, S6  out  2  datapath selects
- accumulate_en, softmax_en, store_en  out  1  Softmax controls

## Operation
- FSM states: IDLE, LOAD, RUN, DRAIN, DONE.
- IDLE: on start go to LOAD with layer_idx=0 and w_addr counter cleared.
- LOAD (1 cycle): latch descriptor[layer_idx].
  - If op==END, go to DONE.
  - Otherwise reset tap_cnt and out_cnt and go to RUN.
  - taps==0 and outs==0 are treated as 1.
  - POOL forces taps=2 regardless of the field.
- RUN: issue (rd_en=1) only in cycles where pe_ready=1.
  - Each issue increments tap_cnt; at taps-1, tap_cnt wraps to 0 and out_cnt increments.
  - After the issue with tap_cnt=taps-1 and out_cnt=outs-1, go to DRAIN.
- Address rules at each issue:
  - CONV: x_addr = out_cnt + tap_cnt.
  - POOL: x_addr = 2*out_cnt + tap_cnt.
  - FC: x_addr = tap_cnt.
  - w_addr: global counter that increments on every issue and is not reset between layers (weights packed contiguously).
  - All addresses wrap modulo 2^AW.
- DRAIN (1 cycle): the last pe_valid is emitted here.
  - Next state is LOAD at layer_idx+1, or DONE if layer_idx==MAX_LAYERS-1.
- DONE (1 cycle): done=1, cfg_err=1 if layer 0 was END, then go to IDLE.
- Control outputs:
  - S1, S2, S3, S5, S6 and store_en are driven from the latched descriptor during LOAD, RUN and DRAIN.
  - accumulate_en = softmax_en = (op==FC) during those states.
  - All control outputs are 0 in IDLE and DONE.
- Descriptor table: cfg_we writes take effect next cycle. Writes during busy are dropped.
- Reset (including mid-sequence): state←IDLE, all counters 0, table cleared to END.

## Timing
- Reset values: every output 0, including xin/win (x_rdata/w_rdata are masked to 0 when pe_valid=0).
- pe_valid and out_strobe are rd_en and the last-tap flag delayed by one register.
- Latency: start sampled at edge k → LOAD at k+1 → first rd_en at k+2 (if pe_ready) → first pe_valid at k+3.
- Layer cost with no stalls: 1 (LOAD) + taps*outs (RUN) + 1 (DRAIN) cycles.
- Stall: pe_ready=0 freezes all counters and addresses; rd_en=0 that cycle, so pe_valid=0 the next cycle. No data is lost or repeated.
- start asserted together with done/IDLE re-entry is ignored; start is accepted only when state==IDLE.
- cfg_we and start in the same IDLE cycle: the write completes first, so the sequence uses the new descriptor.

## Test plan
- Slot0 = CONV taps=3 outs=4, slot1 = END, pe_ready=1, start at cycle 0 → 12 pe_valid pulses in cycles 3–14; x_addr sequence 0,1,2,1,2,3,2,3,4,3,4,5; out_strobe at pulses 3, 6, 9, 12; done at cycle 16.
- CONV taps=2 outs=2 then FC taps=3 outs=1 → w_addr runs 0..6 continuously; FC x_addr 0,1,2; accumulate_en=softmax_en=1 only during the FC layer's LOAD/RUN/DRAIN.
- POOL with descriptor taps=7, outs=3 → taps forced to 2; x_addr 0,1,2,3,4,5; S3 follows the descriptor flag.
- pe_ready toggling 1,0,1,0 on a taps=2 outs=2 layer → exactly 4 pe_valid pulses with no duplicated addresses; layer takes 8 RUN cycles.
- Slot0=END, start → done and cfg_err high together at cycle 2; no rd_en.
- rst_n low for 1 cycle mid-RUN → next cycle all outputs 0 and state IDLE; start without reconfiguration → cfg_err=1.
